nx_ram_1r1w_fifo_ctrl: RTL and testbench

//   Stream-side controller for one nx_ram_1r1w instance: turns valid/ready write and read streams

---
 rtl/nx_ram_1r1w_fifo_ctrl_if.sv | 43 ++++
 rtl/nx_ram_1r1w_fifo_ctrl.sv | 142 ++++++++++++++
 tb/tb_nx_ram_1r1w_fifo_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/nx_ram_1r1w_fifo_ctrl_if.sv
// ============================================================================
// Module   : nx_ram_1r1w_fifo_ctrl_if
// Brief    : Stream (write/read) and RAM-port bundle for nx_ram_1r1w_fifo_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface nx_ram_1r1w_fifo_ctrl_if #(
    parameter int WIDTH = 83,
    parameter int AW    = 8,
    parameter int CW    = 8
);
    logic             wr_vld;
    logic             wr_rdy;
    logic [WIDTH-1:0] wr_dat;
    logic             rd_vld;
    logic             rd_rdy;
    logic [WIDTH-1:0] rd_dat;
    logic             ram_web;
    logic [AW-1:0]    ram_wa;
    logic [WIDTH-1:0] ram_din;
    logic [WIDTH-1:0] ram_bwe;
    logic             ram_reb;
    logic [AW-1:0]    ram_ra;
    logic [WIDTH-1:0] ram_dout;
    logic [CW-1:0]    used_cnt;

    // Environment side: stream producer/consumer plus the RAM model.
    modport master (
        output wr_vld, wr_dat, rd_rdy, ram_dout,
        input  wr_rdy, rd_vld, rd_dat, ram_web, ram_wa, ram_din, ram_bwe,
        input  ram_reb, ram_ra, used_cnt
    );

    // Controller side.
    modport slave (
        input  wr_vld, wr_dat, rd_rdy, ram_dout,
        output wr_rdy, rd_vld, rd_dat, ram_web, ram_wa, ram_din, ram_bwe,
        output ram_reb, ram_ra, used_cnt
    );
endinterface

`default_nettype wire

// File: rtl/nx_ram_1r1w_fifo_ctrl.sv
// ============================================================================
// Module   : nx_ram_1r1w_fifo_ctrl
// Brief    : RAM-backed FIFO controller for nx_ram_1r1w; credit-managed output
//            buffer hides write-commit and read latency. Optional macro
//            NX_RAM_FIFO_CTRL_WMARK_EN adds the used_max watermark port.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module nx_ram_1r1w_fifo_ctrl #(
    parameter  int WIDTH     = 83,
    parameter  int DEPTH     = 168,
    parameter  int AW        = 8,
    parameter  int RD_LAT    = 2,
    localparam int BUF_DEPTH = RD_LAT + 2,
    localparam int CW        = $clog2(DEPTH + BUF_DEPTH + 1)
) (
    input  wire                    clk,
    input  wire                    rst,
    nx_ram_1r1w_fifo_ctrl_if.slave bus
`ifdef NX_RAM_FIFO_CTRL_WMARK_EN
    ,
    output logic [CW-1:0]          used_max
`endif
);

    localparam int BAW = $clog2(BUF_DEPTH);
    localparam int BCW = $clog2(BUF_DEPTH + 1);
    localparam int BOW = BCW + 1;

    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [CW-1:0]    r_ram_cnt;
    logic [CW-1:0]    r_commit_cnt;
    logic [CW-1:0]    r_used_cnt;
    logic             r_wr_d;
    logic [RD_LAT-1:0] r_lat_sr;
    logic [BAW-1:0]   r_bhead;
    logic [BAW-1:0]   r_btail;
    logic [BCW-1:0]   r_buf_cnt;
    logic [WIDTH-1:0] r_buf [BUF_DEPTH];

    logic             w_wr_rdy;
    logic             w_wr_acc;
    logic             w_rd_vld;
    logic             w_pop;
    logic             w_cap;
    logic             w_rd_iss;
    logic [BCW-1:0]   w_inflight;
    logic [BOW-1:0]   w_occ;

    assign w_wr_rdy = ~rst & (r_ram_cnt != CW'(DEPTH));
    assign w_wr_acc = bus.wr_vld & w_wr_rdy;
    assign w_rd_vld = (r_buf_cnt != '0);
    assign w_pop    = w_rd_vld & bus.rd_rdy;
    assign w_cap    = r_lat_sr[RD_LAT-1];

    always_comb begin
        w_inflight = '0;
        for (int i = 0; i < RD_LAT; i++) begin
            w_inflight = w_inflight + BCW'(r_lat_sr[i]);
        end
    end

    // Credits: buffered plus in-flight entries must leave room for one more return.
    assign w_occ    = {1'b0, r_buf_cnt} + {1'b0, w_inflight};
    assign w_rd_iss = ~rst & (r_commit_cnt != '0) & (w_occ < BOW'(BUF_DEPTH));

    assign bus.wr_rdy   = w_wr_rdy;
    assign bus.rd_vld   = w_rd_vld;
    assign bus.rd_dat   = r_buf[r_bhead];
    assign bus.ram_web  = ~w_wr_acc;
    assign bus.ram_wa   = r_wptr;
    assign bus.ram_din  = bus.wr_dat;
    assign bus.ram_bwe  = '1;
    assign bus.ram_reb  = ~w_rd_iss;
    assign bus.ram_ra   = r_rptr;
    assign bus.used_cnt = r_used_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr       <= '0;
            r_rptr       <= '0;
            r_ram_cnt    <= '0;
            r_commit_cnt <= '0;
            r_used_cnt   <= '0;
            r_wr_d       <= 1'b0;
            r_lat_sr     <= '0;
            r_bhead      <= '0;
            r_btail      <= '0;
            r_buf_cnt    <= '0;
        end else begin
            if (w_wr_acc) begin
                r_wptr <= (r_wptr == AW'(DEPTH - 1)) ? '0 : r_wptr + AW'(1);
            end
            if (w_rd_iss) begin
                r_rptr <= (r_rptr == AW'(DEPTH - 1)) ? '0 : r_rptr + AW'(1);
            end
            // RAM registers the write, so the entry is readable one cycle later.
            r_wr_d       <= w_wr_acc;
            r_ram_cnt    <= r_ram_cnt + CW'(w_wr_acc) - CW'(w_rd_iss);
            r_commit_cnt <= r_commit_cnt + CW'(r_wr_d) - CW'(w_rd_iss);
            r_used_cnt   <= r_used_cnt + CW'(w_wr_acc) - CW'(w_pop);

            r_lat_sr[0] <= w_rd_iss;
            for (int i = 1; i < RD_LAT; i++) begin
                r_lat_sr[i] <= r_lat_sr[i-1];
            end

            if (w_cap) begin
                r_btail <= (r_btail == BAW'(BUF_DEPTH - 1)) ? '0 : r_btail + BAW'(1);
            end
            if (w_pop) begin
                r_bhead <= (r_bhead == BAW'(BUF_DEPTH - 1)) ? '0 : r_bhead + BAW'(1);
            end
            r_buf_cnt <= r_buf_cnt + BCW'(w_cap) - BCW'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_cap) begin
            r_buf[r_btail] <= bus.ram_dout;
        end
    end

`ifdef NX_RAM_FIFO_CTRL_WMARK_EN
    logic [CW-1:0] r_used_max;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_used_max <= '0;
        end else if (r_used_cnt > r_used_max) begin
            r_used_max <= r_used_cnt;
        end
    end

    assign used_max = r_used_max;
`endif

endmodule

`default_nettype wire

// File: tb/tb_nx_ram_1r1w_fifo_ctrl.sv
// ============================================================================
// Module   : tb_nx_ram_1r1w_fifo_ctrl
// Brief    : Scoreboard bench for nx_ram_1r1w_fifo_ctrl with a behavioural
//            2-cycle-latency RAM model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_nx_ram_1r1w_fifo_ctrl;

    localparam int WIDTH = 83;
    localparam int DEPTH = 168;
    localparam int AW    = 8;
    localparam int CW    = 8;
    localparam int FULLN = DEPTH + 4;

    logic clk;
    logic rst;
`ifdef NX_RAM_FIFO_CTRL_WMARK_EN
    logic [CW-1:0] used_max;
`endif

    nx_ram_1r1w_fifo_ctrl_if #(.WIDTH(WIDTH), .AW(AW), .CW(CW)) bus ();

    nx_ram_1r1w_fifo_ctrl #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW),
        .RD_LAT(2)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus)
`ifdef NX_RAM_FIFO_CTRL_WMARK_EN
        ,
        .used_max(used_max)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: registered write, address flop then data flop on read.
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    ra_q;
    always @(posedge clk) begin
        if (!bus.ram_web) mem[bus.ram_wa] <= bus.ram_din;
        if (!bus.ram_reb) ra_q <= bus.ram_ra;
        bus.ram_dout <= mem[ra_q];
    end

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int n_pop  = 0;
    int exp_used = 0;
    int exp_wa = 0;
    int exp_ra = 0;
    logic [WIDTH-1:0] exp_q [$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [WIDTH-1:0] dat(input int i);
        return {19'(i * 3), 32'(i) ^ 32'hDEAD_BEEF, 32'(i)};
    endfunction

    // Monitor: pops the scoreboard on every consumed word and tracks occupancy/addresses.
    always @(negedge clk) begin
        logic acc, pop;
        if (!rst) begin
            acc = bus.wr_vld & bus.wr_rdy;
            pop = bus.rd_vld & bus.rd_rdy;
            chk("used_cnt", bus.used_cnt, exp_used);
            if (acc) begin
                chk("ram_web", bus.ram_web, 0);
                chk("ram_wa", bus.ram_wa, exp_wa);
                exp_wa = (exp_wa == DEPTH - 1) ? 0 : exp_wa + 1;
            end
            if (!bus.ram_reb) begin
                chk("ram_ra", bus.ram_ra, exp_ra);
                exp_ra = (exp_ra == DEPTH - 1) ? 0 : exp_ra + 1;
            end
            if (pop) begin
                n_pop++;
                if (exp_q.size() == 0) chk("rd_unexpected", 1, 0);
                else                   chk("rd_dat", bus.rd_dat, exp_q.pop_front());
            end
            exp_used = exp_used + int'(acc) - int'(pop);
        end
    end

    task automatic push_word(input logic [WIDTH-1:0] d);
        bit done = 0;
        bus.wr_vld = 1'b1;
        bus.wr_dat = d;
        for (int t = 0; t < 2000 && !done; t++) begin
            @(negedge clk);
            if (bus.wr_rdy) begin
                exp_q.push_back(d);
                done = 1;
            end
            @(posedge clk); #1;
        end
        if (!done) chk("push_timeout", 1, 0);
    endtask

    task automatic drain(input string name);
        bus.wr_vld = 1'b0;
        bus.rd_rdy = 1'b1;
        for (int t = 0; t < 3000 && exp_q.size() != 0; t++) begin
            @(posedge clk); #1;
        end
        repeat (6) @(posedge clk);
        @(negedge clk);
        chk({name, "_left"}, exp_q.size(), 0);
        chk({name, "_rd_vld"}, bus.rd_vld, 0);
        chk({name, "_used"}, bus.used_cnt, 0);
        @(posedge clk); #1;
    endtask

    task automatic clear_model();
        exp_q.delete();
        exp_used = 0;
        exp_wa = 0;
        exp_ra = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired (t=%0t)", $time);
        $fatal(1);
    end

    initial begin
        int n, u;
        bit pend, once, wdone;
        logic acc, pop;
        int n0, c0, t;

        rst = 1'b1;
        bus.wr_vld = 1'b0;
        bus.wr_dat = '0;
        bus.rd_rdy = 1'b0;
        clear_model();
        repeat (3) @(posedge clk);
        #1;
        bus.wr_vld = 1'b1;
        #1;
        chk("rst_wr_rdy", bus.wr_rdy, 0);
        chk("rst_ram_web", bus.ram_web, 1);
        chk("rst_ram_reb", bus.ram_reb, 1);
        chk("rst_rd_vld", bus.rd_vld, 0);
        chk("rst_used", bus.used_cnt, 0);
        chk("ram_bwe", bus.ram_bwe, {WIDTH{1'b1}});
        bus.wr_vld = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        // Single-word latency: write at T, reb at T+2, rd_vld at T+5.
        bus.rd_rdy = 1'b1;
        bus.wr_vld = 1'b1;
        bus.wr_dat = 83'h5A;
        @(negedge clk);
        chk("lat_web", bus.ram_web, 0);
        chk("lat_wa", bus.ram_wa, 0);
        chk("lat_wr_rdy", bus.wr_rdy, 1);
        exp_q.push_back(83'h5A);
        @(posedge clk); #1;
        bus.wr_vld = 1'b0;
        @(negedge clk);
        chk("lat_reb_t1", bus.ram_reb, 1);
        @(negedge clk);
        chk("lat_reb_t2", bus.ram_reb, 0);
        chk("lat_ra_t2", bus.ram_ra, 0);
        @(negedge clk);
        chk("lat_vld_t3", bus.rd_vld, 0);
        @(negedge clk);
        chk("lat_vld_t4", bus.rd_vld, 0);
        @(negedge clk);
        chk("lat_vld_t5", bus.rd_vld, 1);
        chk("lat_dat_t5", bus.rd_dat, 83'h5A);
        @(posedge clk); #1;
        drain("lat");

        // Fill with the consumer stalled: DEPTH in RAM plus a full output buffer.
        bus.rd_rdy = 1'b0;
        n = 0;
        for (int i = 0; i < 200; i++) begin
            bus.wr_vld = 1'b1;
            bus.wr_dat = dat(n);
            @(negedge clk);
            if (bus.wr_rdy) begin
                exp_q.push_back(dat(n));
                n++;
            end
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("full_accepts", n, FULLN);
        chk("full_used", bus.used_cnt, FULLN);
        chk("full_wr_rdy", bus.wr_rdy, 0);
        chk("full_rd_vld", bus.rd_vld, 1);
        @(posedge clk); #1;

        // Full with write held and pops starting: each accept+pop leaves used_cnt unchanged.
        bus.rd_rdy = 1'b1;
        pend = 0;
        once = 0;
        for (int i = 0; i < 40; i++) begin
            bus.wr_dat = dat(n);
            @(negedge clk);
            acc = bus.wr_vld & bus.wr_rdy;
            pop = bus.rd_vld & bus.rd_rdy;
            if (i == 0) chk("fullpop_wr_rdy0", bus.wr_rdy, 0);
            if (pend) begin
                chk("fullpop_used_const", bus.used_cnt, u);
                pend = 0;
            end
            if (!once && acc && pop) begin
                u = int'(bus.used_cnt);
                pend = 1;
                once = 1;
            end
            if (acc) begin
                exp_q.push_back(dat(n));
                n++;
            end
            @(posedge clk); #1;
        end
        chk("fullpop_seen", once, 1);
        drain("full");

        // Sustained streaming: 1000 words, no bubble after the first output.
        bus.rd_rdy = 1'b1;
        n0 = n_pop;
        fork
            begin
                for (int i = 0; i < 1000; i++) push_word(dat(1000 + i));
                bus.wr_vld = 1'b0;
            end
            begin
                t = 0;
                while (n_pop == n0 && t < 100) begin @(negedge clk); #1; t++; end
                c0 = cyc;
                while (n_pop < n0 + 1000 && t < 5000) begin @(negedge clk); #1; t++; end
                chk("tput_cycles", cyc - c0, 999);
            end
        join
        drain("tput");

        // Wrap with a randomly stalling consumer.
        wdone = 0;
        fork
            begin
                for (int i = 0; i < 400; i++) push_word(dat(5000 + i));
                bus.wr_vld = 1'b0;
                wdone = 1;
            end
            begin
                while (!wdone) begin
                    @(posedge clk); #1;
                    bus.rd_rdy = 1'($urandom_range(0, 1));
                end
            end
        join
        drain("wrap");

        // Reset with reads in flight.
        bus.rd_rdy = 1'b0;
        for (int i = 0; i < 6; i++) push_word(dat(9000 + i));
        bus.wr_vld = 1'b0;
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        chk("mrst_rd_vld", bus.rd_vld, 0);
        chk("mrst_used", bus.used_cnt, 0);
        chk("mrst_web", bus.ram_web, 1);
        chk("mrst_reb", bus.ram_reb, 1);
        chk("mrst_wr_rdy", bus.wr_rdy, 0);
        clear_model();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        bus.rd_rdy = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("mrst_no_stale", bus.rd_vld, 0);
        end
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) push_word(dat(12000 + i));
        drain("post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
